// File: rtl/scramble_parallel.sv
// Parallel BLE-style data whitener: DATA_WIDTH bits per beat through a Galois LFSR,
// with valid/ready handshaking and an automatic reseed at each packet end.
module scramble_parallel #(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  LFSR_LEN   = 7,
    parameter logic [LFSR_LEN-1:0] TAPS       = 7'b0010001,
    parameter int                  CH_W       = LFSR_LEN - 1,
    localparam int                 NB_W       = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH_W-1:0]       channel_number,
    input  logic                  channel_number_load,
    input  logic                  whiten_en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [NB_W-1:0]       in_nbits,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NB_W-1:0]       out_nbits,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned DW = DATA_WIDTH;

    typedef enum logic {IDLE, BUSY} state_e;

    // Seed: lfsr[0]=1, lfsr[k]=ch[CH_W-k] (channel bits reversed above bit 0).
    function automatic logic [LFSR_LEN-1:0] seed(input logic [CH_W-1:0] ch);
        logic [LFSR_LEN-1:0] s;
        s    = '0;
        s[0] = 1'b1;
        for (int unsigned k = 1; k <= CH_W; k++) begin
            if (k < LFSR_LEN) s[k] = ch[CH_W-k];
        end
        return s;
    endfunction

    state_e                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic                  ch_pend_q, ch_pend_d;
    logic [CH_W-1:0]       ch_pend_val_q, ch_pend_val_d;
    logic [LFSR_LEN-1:0]   lfsr_q, lfsr_d;
    logic                  wmode_q, wmode_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [NB_W-1:0]       out_nbits_q, out_nbits_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;

    logic                  accept;
    logic                  mode;
    logic                  wbit;
    logic [LFSR_LEN-1:0]   lfsr_step;
    logic [DATA_WIDTH-1:0] data_x;
    logic [CH_W-1:0]       reload_ch;
    int unsigned           nb;

    assign in_ready  = (!out_valid_q || out_ready) && !(channel_number_load && state_q == IDLE);
    assign out_data  = out_data_q;
    assign out_nbits = out_nbits_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        ch_pend_d     = ch_pend_q;
        ch_pend_val_d = ch_pend_val_q;
        lfsr_d        = lfsr_q;
        wmode_d       = wmode_q;
        out_data_d    = out_data_q;
        out_nbits_d   = out_nbits_q;
        out_last_d    = out_last_q;
        out_valid_d   = out_valid_q;
        reload_ch     = ch_q;
        wbit          = 1'b0;

        accept = in_valid && in_ready;
        mode   = (state_q == IDLE) ? whiten_en : wmode_q;

        nb = DW;
        if (in_last) nb = (32'(in_nbits) > DW) ? DW : 32'(in_nbits);

        lfsr_step = lfsr_q;
        data_x    = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            if (i < nb) begin
                wbit      = lfsr_step[LFSR_LEN-1];
                data_x[i] = in_data[i] ^ (wbit & mode);
                lfsr_step = {lfsr_step[LFSR_LEN-2:0], 1'b0} ^ (wbit ? TAPS : '0);
            end
        end

        // A BUSY-state load is parked; if it coincides with the last beat it feeds the reload directly.
        if (channel_number_load && state_q == BUSY) begin
            ch_pend_d     = 1'b1;
            ch_pend_val_d = channel_number;
        end
        if (channel_number_load && state_q == IDLE) begin
            ch_d   = channel_number;
            lfsr_d = seed(channel_number);
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = data_x;
            out_nbits_d = NB_W'(nb);
            out_last_d  = in_last;
            lfsr_d      = lfsr_step;
            if (state_q == IDLE) wmode_d = whiten_en;
            if (in_last) begin
                reload_ch = ch_pend_d ? ch_pend_val_d : ch_q;
                ch_d      = reload_ch;
                lfsr_d    = seed(reload_ch);
                ch_pend_d = 1'b0;
                state_d   = IDLE;
            end else begin
                state_d = BUSY;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ch_q          <= channel_number;
            ch_pend_q     <= 1'b0;
            ch_pend_val_q <= '0;
            lfsr_q        <= seed(channel_number);
            wmode_q       <= 1'b1;
            out_data_q    <= '0;
            out_nbits_q   <= '0;
            out_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            ch_pend_q     <= ch_pend_d;
            ch_pend_val_q <= ch_pend_val_d;
            lfsr_q        <= lfsr_d;
            wmode_q       <= wmode_d;
            out_data_q    <= out_data_d;
            out_nbits_q   <= out_nbits_d;
            out_last_q    <= out_last_d;
            out_valid_q   <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_scramble_parallel.sv
// Bench for scramble_parallel: directed and random packets checked against a
// bit-stream reference (seed + bit offset within the packet).
module tb_scramble_parallel;

    localparam logic [6:0] TP = 7'b0010001;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] channel_number;
    logic       channel_number_load;
    logic       whiten_en;
    logic [7:0] in_data;
    logic [3:0] in_nbits;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic [3:0] out_nbits;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;

    always #5 clk = ~clk;

    scramble_parallel #(
        .DATA_WIDTH(8),
        .LFSR_LEN  (7),
        .TAPS      (7'b0010001),
        .CH_W      (6)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .channel_number     (channel_number),
        .channel_number_load(channel_number_load),
        .whiten_en          (whiten_en),
        .in_data            (in_data),
        .in_nbits           (in_nbits),
        .in_last            (in_last),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .out_data           (out_data),
        .out_nbits          (out_nbits),
        .out_last           (out_last),
        .out_valid          (out_valid),
        .out_ready          (out_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: packet whitening stream is the serial LFSR output started at Seed(ch).
    function automatic logic [6:0] seed_of(input logic [5:0] ch);
        logic [6:0] s;
        s = 7'd1;
        for (int k = 1; k <= 6; k++) s[k] = ch[6-k];
        return s;
    endfunction

    function automatic logic stream_bit(input logic [6:0] sd, input int p);
        logic [6:0] l;
        logic       w;
        l = sd;
        for (int j = 0; j < p; j++) begin
            w = l[6];
            l = {l[5:0], 1'b0} ^ (w ? TP : 7'd0);
        end
        return l[6];
    endfunction

    bit          m_idle = 1'b1;
    bit          m_pend = 1'b0;
    bit          m_mode = 1'b1;
    logic [5:0]  m_ch, m_pendval;
    logic [6:0]  m_seed;
    int          m_pos;
    logic [12:0] expq[$];
    logic [7:0]  cap[$];
    bit          prev_stall = 1'b0;
    logic [12:0] prev_word;
    bit          bp_pat[$];
    bit          rand_bp = 1'b0;

    always @(negedge clk) begin : mon
        int          n;
        logic [7:0]  d;
        logic        er;
        logic [12:0] e;
        if (rst) begin
            m_idle     = 1'b1;
            m_pend     = 1'b0;
            m_ch       = channel_number;
            prev_stall = 1'b0;
            expq.delete();
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_beat", 32'({out_last, out_nbits, out_data}), 32'(prev_word));
            end
            er = (!out_valid || out_ready) && !(channel_number_load && m_idle);
            chk("in_ready", 32'(in_ready), 32'(er));
            if (out_valid && out_ready) begin
                cap.push_back(out_data);
                e = (expq.size() > 0) ? expq.pop_front() : 13'bx;
                chk("out_beat", 32'({out_last, out_nbits, out_data}), 32'(e));
            end
            if (in_valid && in_ready) begin
                if (m_idle) begin
                    m_mode = whiten_en;
                    m_seed = seed_of(m_ch);
                    m_pos  = 0;
                end
                n = in_last ? ((in_nbits > 4'd8) ? 8 : int'(in_nbits)) : 8;
                d = '0;
                for (int i = 0; i < n; i++) d[i] = in_data[i] ^ (stream_bit(m_seed, m_pos + i) & m_mode);
                m_pos += n;
                expq.push_back({in_last, 4'(n), d});
                if (channel_number_load && !m_idle) begin
                    m_pend    = 1'b1;
                    m_pendval = channel_number;
                end
                if (in_last) begin
                    if (m_pend) m_ch = m_pendval;
                    m_pend = 1'b0;
                    m_idle = 1'b1;
                end else begin
                    m_idle = 1'b0;
                end
            end else if (channel_number_load) begin
                if (m_idle) m_ch = channel_number;
                else begin
                    m_pend    = 1'b1;
                    m_pendval = channel_number;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_nbits, out_data};
        end
    end

    function automatic logic next_ready();
        if (bp_pat.size() > 0) return bp_pat.pop_front();
        if (rand_bp) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic send(input logic [7:0] d, input int nb, input logic last, input logic we);
        int t;
        bit acc;
        in_valid  = 1'b1;
        in_data   = d;
        in_nbits  = 4'(nb);
        in_last   = last;
        whiten_en = we;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            channel_number_load = 1'b0;
            out_ready = next_ready();
            t++;
        end
        chk("send_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((expq.size() > 0 || out_valid) && t < 100) begin
            @(posedge clk);
            #1;
            out_ready = next_ready();
            t++;
        end
        chk("drain_done", 32'(expq.size()), 32'd0);
        bp_pat.delete();
        rand_bp   = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic load_idle(input logic [5:0] ch);
        channel_number      = ch;
        channel_number_load = 1'b1;
        @(negedge clk);
        chk("load_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        channel_number_load = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] data[40];
        logic [7:0] wq[$];
        int         len;
        rst = 1'b1; channel_number = 6'd37; channel_number_load = 1'b0; whiten_en = 1'b1;
        in_data = '0; in_nbits = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_nbits", 32'(out_nbits), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Load strobe in IDLE must block a waiting beat for that cycle.
        in_valid = 1'b1; in_data = 8'h00; in_nbits = 4'd8; in_last = 1'b1;
        load_idle(6'd37);
        chk("load_no_accept", 32'(out_valid), 32'd0);
        send(8'h00, 8, 1'b1, 1'b1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h8D);
        chk("t1_nbits", 32'(out_nbits), 32'd8);
        chk("t1_last", 32'(out_last), 32'd1);
        send(8'h00, 8, 1'b1, 1'b1);
        chk("t1_repeat", 32'(out_data), 32'h8D);

        send(8'hFF, 3, 1'b1, 1'b1);
        chk("part_data", 32'(out_data), 32'h02);
        chk("part_nbits", 32'(out_nbits), 32'd3);
        send(8'h00, 8, 1'b1, 1'b1);
        chk("part_reseed", 32'(out_data), 32'h8D);

        send(8'hA5, 0, 1'b1, 1'b1);
        chk("zero_nbits", 32'(out_nbits), 32'd0);
        chk("zero_data", 32'(out_data), 32'd0);
        send(8'(($urandom)), 3, 1'b0, 1'b1);
        send(8'h00, 15, 1'b1, 1'b1);
        chk("clamp_nbits", 32'(out_nbits), 32'd8);
        drain();

        // 40-byte packet under random backpressure, then de-whiten it.
        for (int i = 0; i < 40; i++) data[i] = 8'($urandom);
        cap.delete();
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) send(data[i], 8, 1'(i == 39), 1'b1);
        drain();
        chk("long_count", 32'(cap.size()), 32'd40);
        if (cap.size() == 40) begin
            chk("long_first_ws", 32'(cap[0] ^ data[0]), 32'h8D);
            wq = cap;
            cap.delete();
            rand_bp = 1'b1;
            for (int i = 0; i < 40; i++) send(wq[i], 8, 1'(i == 39), 1'b1);
            drain();
            chk("dewhite_count", 32'(cap.size()), 32'd40);
            for (int i = 0; i < 40 && i < cap.size(); i++) chk("dewhite", 32'(cap[i]), 32'(data[i]));
        end

        // Fixed stall pattern on a 3-beat packet.
        cap.delete();
        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            data[i] = 8'($urandom);
            send(data[i], 8, 1'(i == 2), 1'b1);
        end
        drain();
        chk("bp_count", 32'(cap.size()), 32'd3);

        // Reload to ch 12 on beat 2 of a ch-37 packet.
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin channel_number = 6'd12; channel_number_load = 1'b1; end
            send(8'($urandom), 8, 1'(i == 3), 1'b1);
        end
        send(8'h00, 8, 1'b1, 1'b1);
        // Load coinciding with the last beat.
        send(8'($urandom), 8, 1'b0, 1'b1);
        channel_number = 6'd5; channel_number_load = 1'b1;
        send(8'($urandom), 8, 1'b1, 1'b1);
        send(8'h00, 8, 1'b1, 1'b1);
        drain();
        load_idle(6'd37);

        // Bypass packet with whiten_en raised mid-packet.
        cap.delete();
        for (int i = 0; i < 3; i++) begin
            data[i] = 8'($urandom);
            send(data[i], 8, 1'(i == 2), 1'(i != 0));
        end
        drain();
        chk("bypass_count", 32'(cap.size()), 32'd3);
        for (int i = 0; i < 3 && i < cap.size(); i++) chk("bypass", 32'(cap[i]), 32'(data[i]));
        send(8'h00, 8, 1'b1, 1'b1);
        chk("after_bypass", 32'(out_data), 32'h8D);
        drain();

        // Random packets, random loads, random backpressure.
        for (int p = 0; p < 25; p++) begin
            len = int'($urandom_range(1, 5));
            rand_bp = 1'b1;
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 5) == 0) begin
                    channel_number = 6'($urandom);
                    channel_number_load = 1'b1;
                end
                send(8'($urandom), (b == len - 1) ? int'($urandom_range(0, 15)) : 8,
                     1'(b == len - 1), 1'($urandom_range(0, 1)));
            end
        end
        drain();

        // Reset with a stalled beat in flight.
        channel_number = 6'd37;
        bp_pat = '{1'b0, 1'b0, 1'b0, 1'b0};
        send(8'h33, 8, 1'b0, 1'b1);
        chk("stall_before_rst", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        bp_pat.delete();
        out_ready = 1'b1;
        send(8'h00, 8, 1'b1, 1'b1);
        chk("after_rst", 32'(out_data), 32'h8D);
        chk("after_rst_last", 32'(out_last), 32'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scramble_parallel.md
Name: scramble_parallel

Overview:
- Parametrised successor to the bit-serial BLE whitening core.
- Whitens or de-whitens DATA_WIDTH bits per clock using a configurable Galois LFSR, with valid/ready backpressure and packet framing.
- The seed reloads automatically at every packet end.
- Sits between the byte/word packet assembler and the GFSK bit serialiser on TX, or between the deserialiser and the CRC checker on RX.

Parameters:
- DATA_WIDTH, 8, bits processed per beat. Bit 0 is first over the air. Range 1..32.
- LFSR_LEN, 7, LFSR length.
- TAPS, 7'b0010001, feedback mask of length LFSR_LEN. Bit k set means lfsr[k] receives lfsr[LFSR_LEN-1] XOR. Default is BLE x^7+x^4+1.
- CH_W, LFSR_LEN-1, channel number width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- channel_number  in  CH_W  whitening seed source
- channel_number_load  in  1  one-cycle strobe; capture channel_number
- whiten_en  in  1  1 = whiten, 0 = bypass; sampled on first beat of a packet
- in_data  in  DATA_WIDTH  input bits
- in_nbits  in  $clog2(DATA_WIDTH+1)  valid bit count; used only when in_last=1, else treated as DATA_WIDTH
- in_last  in  1  last beat of packet
- in_valid  in  1  input valid
- in_ready  out  1  input ready
- out_data  out  DATA_WIDTH  output bits
- out_nbits  out  $clog2(DATA_WIDTH+1)  valid bit count of output beat
- out_last  out  1  last beat marker
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready

Behaviour:
- **Seed.** Seed(ch) is lfsr[0]=1 and lfsr[k]=ch[CH_W-k] for k=1..CH_W (bit-reversed channel).
- **Registers.** ch_reg (CH_W), ch_pend flag plus ch_pend_val, lfsr, packet-mode bit wmode, state IDLE/BUSY, and the output register.
- **Reset.**
  - ch_reg = channel_number; lfsr = Seed(channel_number); state = IDLE; wmode = 1; ch_pend = 0.
  - out_valid = 0, out_data = 0, out_nbits = 0, out_last = 0.
- **in_ready.** in_ready = (!out_valid || out_ready) && !(channel_number_load && state==IDLE). It is combinational from out_ready.
- **Accept.** A beat is accepted when in_valid && in_ready.
- **Latency.** Exactly 1 cycle, accept to out_valid. Full throughput (1 beat/cycle) while out_ready=1.
- **Output hold.** out_valid stays high until out_ready=1. out_data, out_nbits and out_last are stable while out_valid && !out_ready.
- **Per-bit step, i = 0..n-1** (n = in_nbits if in_last, else DATA_WIDTH):
  - w_i = lfsr[LFSR_LEN-1].
  - Output bit i = in_data[i] ^ (w_i & mode).
  - lfsr = {lfsr[LFSR_LEN-2:0],0} ^ (w_i ? TAPS : 0).
  - The whole chain is unrolled combinationally in one cycle.
  - out_data bits i >= n are 0. out_nbits = n. out_last = in_last.
- **Bit-count edge cases.** in_nbits=0 with in_last=1 produces a beat with out_nbits=0 and leaves the LFSR unadvanced. in_nbits > DATA_WIDTH is clamped to DATA_WIDTH.
- **Mode.** mode = whiten_en on the first beat of a packet (state IDLE), and that value is latched into wmode. For later beats mode = wmode; whiten_en is ignored mid-packet.
- **State machine.**
  - IDLE, accept with in_last=0 -> BUSY.
  - IDLE or BUSY, accept with in_last=1 -> IDLE, and lfsr = Seed(ch_pend ? ch_pend_val : ch_reg). ch_reg updates to match and ch_pend clears.
  - Otherwise hold state.
- **channel_number_load in IDLE.** ch_reg = channel_number and lfsr = Seed(channel_number) next cycle. No beat is accepted that cycle.
- **channel_number_load in BUSY.**
  - ch_pend = 1 and ch_pend_val = channel_number; the current packet is unaffected.
  - The latest load wins.
  - A load in the same cycle as an accepted last beat is applied by the end-of-packet reload.
- **Bypass.** Out = in, but the LFSR still advances and reseeds exactly as in whiten mode.
- **Reset mid-packet.** Any in-flight output beat is dropped and the state returns to IDLE.

Test Plan:
- DATA_WIDTH=8, load ch 37, whiten_en=1, one beat in_data=0x00, in_last=1 -> out_data=0x8D, out_nbits=8, out_last=1 one cycle after accept. A bit-serial golden model gives first whitening bits 1,0,1,1,0,0,0,1.
- Same packet sent twice back-to-back, no reload strobe between -> both outputs 0x8D (auto reseed on last). A 40-byte packet on ch 37 matches the serial golden model bit for bit, and de-whitening the output returns the original data.
- Packet of 3 beats with out_ready toggled 1,0,0,1,0,1 -> out_data held stable during stalls, no beat lost or duplicated, in_ready=0 whenever out_valid && !out_ready.
- channel_number_load ch=12 issued on beat 2 of a 4-beat ch-37 packet -> beats 3-4 continue the ch-37 sequence; the next packet starts with the Seed(12) sequence.
- whiten_en=0 at first beat, toggled to 1 mid-packet -> all beats out == in. Next packet with whiten_en=1 is whitened from the correct seed.
- Last beat in_nbits=3, in_data=0xFF, ch 37, single beat -> out_data=0x02 (bits 0..2 = 0,1,0), out_nbits=3. A following packet starts from Seed(37). Assert rst mid-packet -> out_valid=0 next cycle, state IDLE.
